rrp_otf_convert: RTL and testbench



---
 rtl/rrp_otf_convert.sv | 149 ++++++++++++++
 tb/tb_rrp_otf_convert.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rrp_otf_convert.sv
// MSD-first on-the-fly conversion of a radix-RADIX signed-digit word to two's complement.
// Optional illegal-digit (-RADIX) detection enabled by defining RRP_OTF_DIGIT_CHECK_EN.
module rrp_otf_convert #(
  parameter int unsigned RADIX = 2,
  parameter int unsigned WIDTH = 7,
  localparam int unsigned K      = $clog2(RADIX),
  localparam int unsigned D      = K + 1,
  localparam int unsigned DIGITS = 2 * WIDTH + 1,
  localparam int unsigned B      = K * DIGITS + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [D*DIGITS-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [B-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              dig_err
);

  localparam int unsigned CW      = $clog2(DIGITS);
  localparam logic [B-1:0] RADIX_B = B'(RADIX);
  localparam logic [B-1:0] ONE_B   = B'(1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_d;
  logic [D*DIGITS-1:0] word_q, word_d;
  logic [B-1:0]       q_q, q_d, qm_q, qm_d;
  logic [B-1:0]       out_data_q, out_data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [D-1:0]       dig;
  logic [B-1:0]       dig_ext, q_next, qm_next;
  logic               dig_neg, dig_pos;

  // Q holds the prefix value, QM holds prefix-1; the digit sign picks the source.
  always_comb begin
    dig     = word_q[cnt_q*D +: D];
    dig_ext = {{(B-D){dig[D-1]}}, dig};
    dig_neg = dig[D-1];
    dig_pos = !dig_neg && (dig != '0);
    q_next  = dig_neg ? (qm_q << K) + dig_ext + RADIX_B
                      : (q_q  << K) + dig_ext;
    qm_next = dig_pos ? (q_q  << K) + dig_ext - ONE_B
                      : (qm_q << K) + dig_ext + RADIX_B - ONE_B;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    q_d         = q_q;
    qm_d        = qm_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d     = in_data;
          q_d        = '0;
          qm_d       = '1;
          cnt_d      = CNT_TOP;
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        q_d  = q_next;
        qm_d = qm_next;
        if (cnt_q == '0) begin
          out_data_d  = q_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      cnt_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef RRP_OTF_DIGIT_CHECK_EN
  localparam logic [D-1:0] NEG_R = {1'b1, {K{1'b0}}};

  logic dig_err_q, dig_err_d;

  // Sticky per word: cleared on accept, set by any -RADIX digit during conversion.
  always_comb begin
    dig_err_d = dig_err_q;
    if (state_q == IDLE && in_valid) begin
      dig_err_d = 1'b0;
    end else if (state_q == CONV && dig == NEG_R) begin
      dig_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig_err_q <= 1'b0;
    end else begin
      dig_err_q <= dig_err_d;
    end
  end

  assign dig_err = dig_err_q;
`else
  assign dig_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrp_otf_convert.sv
// Bench for rrp_otf_convert: radix-2/width-7 and radix-4/width-2 instances against a digit-sum model.
module tb_rrp_otf_convert;

  localparam int unsigned RA = 2, WA = 7, DA = 2, NA = 15, BA = 16;
  localparam int unsigned RB = 4, WB = 2, DB = 3, NB = 5, BB = 11;
`ifdef RRP_OTF_DIGIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [DA*NA-1:0] in_data_a;
  logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, dig_err_a;
  logic [BA-1:0]    out_data_a;
  logic [DB*NB-1:0] in_data_b;
  logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, dig_err_b;
  logic [BB-1:0]    out_data_b;

  rrp_otf_convert #(.RADIX(RA), .WIDTH(WA)) dut_a (
    .clock(clock), .reset(reset),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .dig_err(dig_err_a)
  );

  rrp_otf_convert #(.RADIX(RB), .WIDTH(WB)) dut_b (
    .clock(clock), .reset(reset),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .dig_err(dig_err_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DA*NA-1:0] enc_a(input int d[NA]);
    logic [DA*NA-1:0] r;
    r = '0;
    for (int i = 0; i < NA; i++) r[i*DA +: DA] = DA'(d[i]);
    return r;
  endfunction

  function automatic longint val_a(input int d[NA]);
    longint s = 0;
    longint p = 1;
    for (int i = 0; i < NA; i++) begin
      s += longint'(d[i]) * p;
      p *= RA;
    end
    return s;
  endfunction

  function automatic logic [DB*NB-1:0] enc_b(input int d[NB]);
    logic [DB*NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*DB +: DB] = DB'(d[i]);
    return r;
  endfunction

  function automatic longint val_b(input int d[NB]);
    longint s = 0;
    longint p = 1;
    for (int i = 0; i < NB; i++) begin
      s += longint'(d[i]) * p;
      p *= RB;
    end
    return s;
  endfunction

  task automatic run_a(input logic [DA*NA-1:0] w, input longint exp, input bit chk_data,
                       input bit exp_err, input int hold, input string tag);
    int n;
    n = 0;
    while (!in_ready_a && n < 50) begin tick(); n++; end
    check({tag, " ready_before"}, longint'(in_ready_a), 1);
    in_data_a  = w;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    in_data_a  = '0;
    check({tag, " busy"}, longint'(in_ready_a), 0);
    n = 0;
    while (!out_valid_a && n < 100) begin tick(); n++; end
    check({tag, " latency"}, longint'(n), longint'(NA));
    for (int i = 0; i <= hold; i++) begin
      if (chk_data) check({tag, " data"}, longint'($signed(out_data_a)), exp);
      check({tag, " valid_held"}, longint'(out_valid_a), 1);
      check({tag, " ready_low"}, longint'(in_ready_a), 0);
      check({tag, " dig_err"}, longint'(dig_err_a), longint'(exp_err));
      if (i < hold) tick();
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    check({tag, " valid_drop"}, longint'(out_valid_a), 0);
    check({tag, " ready_back"}, longint'(in_ready_a), 1);
    if (chk_data) check({tag, " data_kept"}, longint'($signed(out_data_a)), exp);
  endtask

  task automatic run_b(input logic [DB*NB-1:0] w, input longint exp, input string tag);
    int n;
    n = 0;
    while (!in_ready_b && n < 50) begin tick(); n++; end
    check({tag, " ready_before"}, longint'(in_ready_b), 1);
    in_data_b  = w;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 50) begin tick(); n++; end
    check({tag, " latency"}, longint'(n), longint'(NB));
    check({tag, " data"}, longint'($signed(out_data_b)), exp);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    check({tag, " valid_drop"}, longint'(out_valid_b), 0);
  endtask

  initial begin
    int da[NA];
    int db[NB];
    in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (2) tick();
    check("rst in_ready", longint'(in_ready_a), 1);
    check("rst out_valid", longint'(out_valid_a), 0);
    check("rst out_data", longint'(out_data_a), 0);
    check("rst dig_err", longint'(dig_err_a), 0);
    check("rst b in_ready", longint'(in_ready_b), 1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NA; i++) da[i] = 0;
    run_a(enc_a(da), 0, 1'b1, 1'b0, 0, "zeros");
    run_a(enc_a(da), 0, 1'b1, 1'b0, 0, "zeros2");

    da[14] = 1; da[0] = -1;
    run_a(enc_a(da), 16383, 1'b1, 1'b0, 0, "msd_lsd");

    for (int i = 0; i < NA; i++) da[i] = -1;
    run_a(enc_a(da), -32767, 1'b1, 1'b0, 5, "all_neg_bp");

    db[4] = 3; db[3] = -3; db[2] = 0; db[1] = 2; db[0] = -1;
    run_b(enc_b(db), 583, "r4_dir");

    for (int i = 0; i < NA; i++) da[i] = 0;
    da[5] = -2;
    run_a(enc_a(da), 0, 1'b0, CHK_EN, 1, "illegal");
    da[5] = 1;
    run_a(enc_a(da), 32, 1'b1, 1'b0, 0, "after_illegal");

    // Abort mid-conversion, then confirm no residue carries into the next word.
    for (int i = 0; i < NA; i++) da[i] = -1;
    in_data_a = enc_a(da);
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    #1;
    check("abort out_valid", longint'(out_valid_a), 0);
    check("abort in_ready", longint'(in_ready_a), 1);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < NA; i++) da[i] = 0;
    da[0] = 1;
    run_a(enc_a(da), 1, 1'b1, 1'b0, 0, "post_abort");

    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < NA; i++) da[i] = int'($urandom_range(0, 2)) - 1;
      run_a(enc_a(da), val_a(da), 1'b1, 1'b0, int'($urandom_range(0, 3)), "rand_a");
    end

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NB; i++) db[i] = int'($urandom_range(0, 6)) - 3;
      run_b(enc_b(db), val_b(db), "rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
